up_axi_master: RTL

// - Initiator-side counterpart of the up_* register bus: turns single-cycle up_wreq/up_rreq

---
 rtl/up_axi_master_pkg.sv | 27 ++
 rtl/up_axi_master_tmo.sv | 30 +++
 rtl/up_axi_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/up_axi_master_pkg.sv
// Shared definitions for the up_* to AXI4-Lite initiator: FSM encoding,
// AXI response codes and the fixed channel attributes.
package up_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0]  AXI_RESP_EXOKAY  = 2'b01;
    localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR  = 2'b11;

    localparam logic [31:0] TIMEOUT_DATA     = 32'hDEADDEAD;
    localparam logic [2:0]  AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0]  AXI_STRB_DEFAULT = 4'hf;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/up_axi_master_tmo.sv
// Per-transaction watchdog: cleared while idle, counts active cycles and
// saturates at the limit; a limit of 0 never expires.
module up_axi_master_tmo #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/up_axi_master.sv
// Turns single-cycle up_wreq/up_rreq pulses into one-at-a-time AXI4-Lite
// master transactions, returning up_wack/up_rack with a watchdog error path.
import up_axi_master_pkg::*;

// state      | meaning
// IDLE       | waiting for a request, or about to issue the latched read
// WR_AW_W    | AW and W valids up, each dropped on its own ready
// WR_B       | bready up, waiting for the write response
// RD_AR      | arvalid up, waiting for arready
// RD_R       | rready up, waiting for read data
// DRAIN      | error ack already given, finishing the AXI handshakes silently
module up_axi_master #(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    output logic                         up_werr,
    input  logic                         up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    output logic [31:0]                  up_rdata,
    output logic                         up_rack,
    output logic                         up_rerr,
    output logic                         up_busy,
    output logic                         up_drop,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    input  logic [1:0]                   m_axi_bresp,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [31:0]                  m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp
);

    state_t                       r_state;
    logic                         r_rd_pend, r_is_wr;
    logic                         r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [AXI_ADDRESS_WIDTH-1:0] r_awaddr, r_araddr;
    logic [31:0]                  r_wdata, r_rdata;
    logic                         r_wack, r_werr, r_rack, r_rerr, r_drop;

    logic w_idle_free, w_drop, w_aw_done, w_w_done, w_tmo_en, w_expire;

    assign w_idle_free = (r_state == ST_IDLE) && !r_rd_pend;
    assign w_drop      = (up_wreq || up_rreq) && !w_idle_free;
    assign w_aw_done   = !r_awvalid || m_axi_awready;
    assign w_w_done    = !r_wvalid  || m_axi_wready;
    assign w_tmo_en    = (r_state == ST_WR_AW_W) || (r_state == ST_WR_B) ||
                         (r_state == ST_RD_AR)   || (r_state == ST_RD_R);

    up_axi_master_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .up_clk   (up_clk),
        .up_rstn  (up_rstn),
        .i_clr    (r_state == ST_IDLE),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state   <= ST_IDLE;
            r_rd_pend <= 1'b0;
            r_is_wr   <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_wack    <= 1'b0;
            r_werr    <= 1'b0;
            r_rack    <= 1'b0;
            r_rerr    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_wack <= 1'b0;
            r_werr <= 1'b0;
            r_rack <= 1'b0;
            r_rerr <= 1'b0;
            r_drop <= w_drop;
            case (r_state)
                ST_IDLE: begin
                    if (r_rd_pend) begin
                        r_rd_pend <= 1'b0;
                        r_is_wr   <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_RD_AR;
                    end else if (up_wreq) begin
                        r_awaddr  <= {up_waddr, 2'b00};
                        r_wdata   <= up_wdata;
                        r_is_wr   <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_WR_AW_W;
                        if (up_rreq) begin
                            r_rd_pend <= 1'b1;
                            r_araddr  <= {up_raddr, 2'b00};
                        end
                    end else if (up_rreq) begin
                        r_araddr  <= {up_raddr, 2'b00};
                        r_is_wr   <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_RD_AR;
                    end
                end
                ST_WR_AW_W: begin
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_B;
                    end else if (w_expire) begin
                        r_wack  <= 1'b1;
                        r_werr  <= 1'b1;
                        r_state <= ST_DRAIN;
                        if (r_rd_pend) begin
                            r_rd_pend <= 1'b0;
                            r_drop    <= 1'b1;
                        end
                    end
                end
                ST_WR_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_wack   <= 1'b1;
                        r_werr   <= resp_err(m_axi_bresp);
                        r_state  <= ST_IDLE;
                    end else if (w_expire) begin
                        r_wack  <= 1'b1;
                        r_werr  <= 1'b1;
                        r_state <= ST_DRAIN;
                        if (r_rd_pend) begin
                            r_rd_pend <= 1'b0;
                            r_drop    <= 1'b1;
                        end
                    end
                end
                ST_RD_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_R;
                    end else if (w_expire) begin
                        r_rack  <= 1'b1;
                        r_rerr  <= 1'b1;
                        r_rdata <= TIMEOUT_DATA;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_RD_R: begin
                    if (m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_rack   <= 1'b1;
                        r_rdata  <= m_axi_rdata;
                        r_rerr   <= resp_err(m_axi_rresp);
                        r_state  <= ST_IDLE;
                    end else if (w_expire) begin
                        r_rack  <= 1'b1;
                        r_rerr  <= 1'b1;
                        r_rdata <= TIMEOUT_DATA;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Finish whatever handshakes are still open; the slave must not see valids vanish.
                    if (r_is_wr) begin
                        if (m_axi_awready) r_awvalid <= 1'b0;
                        if (m_axi_wready)  r_wvalid  <= 1'b0;
                        if (w_aw_done && w_w_done && !r_bready) r_bready <= 1'b1;
                        if (r_bready && m_axi_bvalid) begin
                            r_bready <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        if (r_arvalid && m_axi_arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                        end
                        if (r_rready && m_axi_rvalid) begin
                            r_rready <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign up_wack       = r_wack;
    assign up_werr       = r_werr;
    assign up_rack       = r_rack;
    assign up_rerr       = r_rerr;
    assign up_rdata      = r_rdata;
    assign up_drop       = r_drop;
    assign up_busy       = !w_idle_free;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = AXI_STRB_DEFAULT;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_rready  = r_rready;

endmodule
